// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the BCD frequency counter.
// Provides the BCD nibble type, seven-segment patterns and sync depth.
package freq_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam int SYNC_STAGES = 2;

    localparam bcd_t BCD_NINE  = 4'd9;
    localparam bcd_t BCD_BLANK = 4'hF;

    // Active-high segments, bit order gfedcba.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/freq_counter_bcd_seven_segment_decoder.sv
// BCD nibble to seven-segment decoder, blank for values 10..15.
// Ports: nibble (in, 4) value; seg (out, 7) active-high gfedcba.
module seven_segment_decoder
    import freq_counter_pkg::*;
(
    input  bcd_t       nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/freq_counter_bcd.sv
// Gated BCD frequency counter with latched result and muxed display.
// Ports: clk, reset (sync high), signal, period_load/period (gate
// reload), bcd_out/count_valid/overflow (result), segments/digit.
module freq_counter_bcd
    import freq_counter_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int PERIOD_W       = 16,
    parameter int DEFAULT_PERIOD = 1000,
    parameter int REFRESH_W      = 10,
    parameter int BLANK_ZEROS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  signal,
    input  logic                  period_load,
    input  logic [PERIOD_W-1:0]   period,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  count_valid,
    output logic                  overflow,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic [PERIOD_W-1:0]    period_q, period_d;
    logic [PERIOD_W-1:0]    gate_q, gate_d;
    logic [4*DIGITS-1:0]    cnt_q, cnt_d;
    logic                   ovf_win_q, ovf_win_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic [REFRESH_W-1:0]   refresh_q, refresh_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0]      digit_q, digit_d;
    logic [6:0]             segments_q, segments_d;

    logic                   sync_bit;
    logic                   edge_hit;
    logic [PERIOD_W-1:0]    period_eff;
    logic                   terminal;
    logic [DIGITS:0]        carry;
    logic [4*DIGITS-1:0]    cnt_inc;
    logic [4*DIGITS-1:0]    cnt_next;
    logic                   sat;
    logic                   ovf_next;
    bcd_t                   sel_nib;
    logic                   sel_blank;
    logic                   hi_zero;
    bcd_t                   dec_in;
    logic [6:0]             seg_dec;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign edge_hit = sync_bit & ~edge_q;

    // A zero period behaves as a one-cycle window.
    assign period_eff = (period_q == '0) ? PERIOD_W'(1) : period_q;
    assign terminal   = (gate_q == period_eff - PERIOD_W'(1));

    assign carry[0] = edge_hit;

    for (genvar k = 0; k < DIGITS; k++) begin : g_decade
        bcd_t cur;
        assign cur          = cnt_q[4*k +: 4];
        assign carry[k+1]   = carry[k] & (cur == BCD_NINE);
        assign cnt_inc[4*k +: 4] = !carry[k] ? cur :
                                   (cur == BCD_NINE) ? 4'd0 :
                                   cur + 4'd1;
    end

    // A carry out of the top decade means all decades were 9.
    assign sat      = carry[DIGITS];
    assign cnt_next = sat ? cnt_q : cnt_inc;
    assign ovf_next = ovf_win_q | sat;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], signal};
        edge_d    = sync_bit;
        period_d  = period_q;
        gate_d    = gate_q + PERIOD_W'(1);
        cnt_d     = cnt_next;
        ovf_win_d = ovf_next;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        if (period_load) begin
            period_d  = period;
            gate_d    = '0;
            cnt_d     = '0;
            ovf_win_d = 1'b0;
        end else if (terminal) begin
            bcd_d     = cnt_next;
            ovf_d     = ovf_next;
            valid_d   = 1'b1;
            gate_d    = '0;
            cnt_d     = '0;
            ovf_win_d = 1'b0;
        end
    end

    always_comb begin
        refresh_d = refresh_q + REFRESH_W'(1);
        idx_d     = idx_q;
        if (&refresh_q) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Walk from the top decade so hi_zero means "this and all above".
    always_comb begin
        sel_nib   = '0;
        sel_blank = 1'b0;
        hi_zero   = 1'b1;
        digit_d   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            hi_zero = hi_zero & (bcd_q[4*k +: 4] == 4'd0);
            if (idx_q == IDX_W'(k)) begin
                sel_nib    = bcd_q[4*k +: 4];
                sel_blank  = hi_zero & (k != 0);
                digit_d[k] = 1'b1;
            end
        end
        dec_in     = (BLANK_ZEROS != 0 && sel_blank) ? BCD_BLANK : sel_nib;
        segments_d = seg_dec;
    end

    seven_segment_decoder u_dec (
        .nibble (dec_in),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            edge_q     <= 1'b0;
            period_q   <= PERIOD_W'(DEFAULT_PERIOD);
            gate_q     <= '0;
            cnt_q      <= '0;
            ovf_win_q  <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            refresh_q  <= '0;
            idx_q      <= '0;
            digit_q    <= DIGITS'(1);
            segments_q <= SEG_0;
        end else begin
            sync_q     <= sync_d;
            edge_q     <= edge_d;
            period_q   <= period_d;
            gate_q     <= gate_d;
            cnt_q      <= cnt_d;
            ovf_win_q  <= ovf_win_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            refresh_q  <= refresh_d;
            idx_q      <= idx_d;
            digit_q    <= digit_d;
            segments_q <= segments_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign count_valid = valid_q;
    assign overflow    = ovf_q;
    assign segments    = segments_q;
    assign digit       = digit_q;

endmodule
